// File: rtl/perf_stats_collector.sv
// Run-statistics accumulator fed by the cycle/idle performance counter.
// Two-stage sample pipeline plus an atomic snapshot register set read out over valid/ready.
module perf_stats_collector #(
    parameter int COUNT_W = 32,
    parameter int DATA_W  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_valid,
    input  logic [DATA_W-1:0]  sample_cycles,
    input  logic [DATA_W-1:0]  sample_idle,
    input  logic               clear,
    input  logic               snap_req,
    output logic               snap_valid,
    input  logic               snap_ready,
    output logic [COUNT_W-1:0] snap_runs,
    output logic [DATA_W-1:0]  snap_sum_cycles,
    output logic [DATA_W-1:0]  snap_sum_idle,
    output logic [DATA_W-1:0]  snap_min_cycles,
    output logic [DATA_W-1:0]  snap_max_cycles,
    output logic [DATA_W-1:0]  snap_last_cycles,
    output logic               snap_overflow
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam logic [DATA_W-1:0]  DATA_MAX  = '1;
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    // Stage 1: registered sample
    logic              s1_valid_reg;
    logic [DATA_W-1:0] s1_cycles_reg;
    logic [DATA_W-1:0] s1_idle_reg;

    // Stage 2: accumulators
    logic [COUNT_W-1:0]          runs_reg;
    logic [COUNT_W-1:0]          runs_next;
    logic                        runs_sat;
    logic [1:0][DATA_W-1:0]      sum_reg;
    logic [1:0][DATA_W-1:0]      sum_next;
    logic [1:0]                  sum_sat;
    logic [DATA_W-1:0]           min_reg;
    logic [DATA_W-1:0]           max_reg;
    logic [DATA_W-1:0]           last_reg;
    logic                        overflow_reg;

    // Snapshot registers
    logic [0:0]         state_reg;
    logic [COUNT_W-1:0] snap_runs_reg;
    logic [DATA_W-1:0]  snap_sum_cycles_reg;
    logic [DATA_W-1:0]  snap_sum_idle_reg;
    logic [DATA_W-1:0]  snap_min_reg;
    logic [DATA_W-1:0]  snap_max_reg;
    logic [DATA_W-1:0]  snap_last_reg;
    logic               snap_overflow_reg;

    assign runs_sat  = (runs_reg == COUNT_MAX);
    assign runs_next = runs_sat ? runs_reg : runs_reg + COUNT_W'(1);

    // Index 0 accumulates cycles, index 1 accumulates idle cycles; both clamp on carry-out.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sum
            logic [DATA_W-1:0] addend;
            logic [DATA_W:0]   wide;
            assign addend       = (gi == 0) ? s1_cycles_reg : s1_idle_reg;
            assign wide         = {1'b0, sum_reg[gi]} + {1'b0, addend};
            assign sum_sat[gi]  = wide[DATA_W];
            assign sum_next[gi] = wide[DATA_W] ? DATA_MAX : wide[DATA_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            s1_valid_reg  <= 1'b0;
            s1_cycles_reg <= '0;
            s1_idle_reg   <= '0;
            runs_reg      <= '0;
            sum_reg       <= '0;
            min_reg       <= DATA_MAX;
            max_reg       <= '0;
            last_reg      <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            s1_valid_reg  <= sample_valid;
            s1_cycles_reg <= sample_cycles;
            s1_idle_reg   <= sample_idle;
            if (s1_valid_reg) begin
                runs_reg <= runs_next;
                sum_reg  <= sum_next;
                min_reg  <= (s1_cycles_reg < min_reg) ? s1_cycles_reg : min_reg;
                max_reg  <= (s1_cycles_reg > max_reg) ? s1_cycles_reg : max_reg;
                last_reg <= s1_cycles_reg;
                if (runs_sat || (|sum_sat)) begin
                    overflow_reg <= 1'b1;
                end
            end
        end
    end

    // Snapshot captures pre-update accumulator values; clear never touches a held snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg           <= ST_IDLE;
            snap_runs_reg       <= '0;
            snap_sum_cycles_reg <= '0;
            snap_sum_idle_reg   <= '0;
            snap_min_reg        <= '0;
            snap_max_reg        <= '0;
            snap_last_reg       <= '0;
            snap_overflow_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (snap_req) begin
                        state_reg           <= ST_HOLD;
                        snap_runs_reg       <= runs_reg;
                        snap_sum_cycles_reg <= sum_reg[0];
                        snap_sum_idle_reg   <= sum_reg[1];
                        snap_min_reg        <= (runs_reg == '0) ? '0 : min_reg;
                        snap_max_reg        <= (runs_reg == '0) ? '0 : max_reg;
                        snap_last_reg       <= last_reg;
                        snap_overflow_reg   <= overflow_reg;
                    end
                end
                ST_HOLD: begin
                    if (snap_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign snap_valid       = (state_reg == ST_HOLD);
    assign snap_runs        = snap_runs_reg;
    assign snap_sum_cycles  = snap_sum_cycles_reg;
    assign snap_sum_idle    = snap_sum_idle_reg;
    assign snap_min_cycles  = snap_min_reg;
    assign snap_max_cycles  = snap_max_reg;
    assign snap_last_cycles = snap_last_reg;
    assign snap_overflow    = snap_overflow_reg;

endmodule

// File: doc/perf_stats_collector.md
Name: perf_stats_collector

Overview:
- Downstream consumer of the cycle/idle performance counter.
- Each time a measurement completes, it takes the counter's final cycles and idle_cycles values and accumulates run statistics: run count, sum, min and max of cycles, sum of idle cycles, and the last run.
- Statistics are read out as an atomic snapshot over a valid/ready handshake, for the host register interface or debug stream.

Parameters:
- COUNT_W, 32, width of the run counter; saturates at all-ones.
- DATA_W, 64, width of cycle values and accumulators; matches data64_t.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- sample_valid  in  1  one-cycle pulse: a measurement finished and the sample_* values are final. Integration drives it one cycle after the counter's terminating last, when the counter output registers have settled.
- sample_cycles  in  DATA_W  total cycles of the finished run.
- sample_idle  in  DATA_W  idle cycles of the finished run.
- clear  in  1  pulse: zero all statistics and flush the pipeline.
- snap_req  in  1  pulse: request a statistics snapshot.
- snap_valid  out  1  snapshot outputs are valid.
- snap_ready  in  1  consumer accepts the snapshot.
- snap_runs  out  COUNT_W  number of runs accumulated.
- snap_sum_cycles  out  DATA_W  saturating sum of cycles.
- snap_sum_idle  out  DATA_W  saturating sum of idle cycles.
- snap_min_cycles  out  DATA_W  minimum cycles; 0 if runs==0.
- snap_max_cycles  out  DATA_W  maximum cycles; 0 if runs==0.
- snap_last_cycles  out  DATA_W  cycles of the most recent run.
- snap_overflow  out  1  sticky: some sum or the run count saturated since the last clear/reset.

Behaviour:
- Reset (rst high at a clk edge): all accumulators 0, internal min register all-ones, overflow 0, pipeline empty, snapshot FSM in IDLE.
- Reset output values: snap_valid=0 and all snap_* outputs=0.
- Reset mid-handshake: snap_valid drops the next cycle. No snapshot is retained.

Pipeline (2 stages):
- S1 registers sample_valid/cycles/idle.
- S2 updates the accumulators from S1.
- sample_valid at edge t → accumulators reflect the sample after edge t+2.
- Back-to-back sample_valid every cycle is supported with no loss.

Accumulator update on an S1 valid:
- runs += 1, saturating at 2^COUNT_W-1.
- sum_cycles += cycles and sum_idle += idle, each saturating at 2^DATA_W-1.
- Any saturation event sets overflow. Once saturated, a value stays at max.
- min = smaller of (min, cycles); max = larger of (max, cycles); last = cycles.
- No check is made that idle ≤ cycles; values are stored as given.

clear:
- At the edge where clear=1: accumulators return to reset values and both pipeline stages are invalidated.
- A sample_valid in the same cycle as clear is dropped.
- A sample already in S1/S2 is dropped.
- clear does not affect a snapshot already held.

Snapshot FSM:
- IDLE: snap_req=1 → capture the current registered accumulator values (before any S2 update at that same edge) into the snap_* registers, then go to HOLD. snap_valid=1 from the next cycle.
  - min/max are reported as 0 when captured runs==0.
- HOLD: snap_valid=1 and snap_* stable until snap_valid && snap_ready.
  - On that handshake → IDLE, snap_valid=0 the next cycle.
  - snap_req while in HOLD is ignored (not queued).
- snap_req and clear in the same cycle: the snapshot captures the pre-clear values.
- Snapshots never stall sampling: accumulation continues while HOLD is waiting.

Test Plan:
- Reset, then samples (cycles, idle) = (10,2), (4,0), (7,3), then snap_req with snap_ready=1 → runs=3, sum_cycles=21, sum_idle=5, min=4, max=10, last=7, overflow=0.
- No samples, snap_req → runs=0, min=0, max=0, sums=0; snap_valid held while snap_ready=0 for 5 cycles with values stable, deasserting 1 cycle after snap_ready=1.
- sample_valid at cycle t with cycles=5, snap_req at t+1 → snapshot runs=0; snap_req at t+2 → runs=1, last=5 (verifies 2-cycle latency).
- Samples on 4 consecutive cycles (1,2,3,4), clear asserted in the same cycle as the 4th sample → after 2 more cycles a snapshot gives runs=0; one subsequent sample of 9 gives runs=1, min=max=9.
- Sample cycles=2^64-3, then cycles=5 → sum_cycles=2^64-1, overflow=1; after clear → overflow=0, sum=0.
- rst asserted while snap_valid=1 in HOLD → snap_valid=0 next cycle, all snap_* outputs=0, and a following snap_req produces runs=0.
